swc_alloc_arbiter: RTL and testbench
====================================

Name: swc_alloc_arbiter

Overview:
- Shares the single command port of the swcore page allocator among g_num_ports requesters (RX/TX port logic).
- Each requester issues one of ALLOC, FREE, FORCE_FREE or SET_USECOUNT.
- The arbiter grants round-robin, drives the allocator command, waits for allocator done, then returns a one-cycle done pulse plus the allocated page to the granted requester.
- Allocation requests are held back while the allocator reports no free memory.

Parameters:
- g_num_ports, 4: number of requesters, 2..16.
- g_page_addr_width, 10: page address width. Must match the allocator.
- g_usecnt_width, 5: use-count width. Must match the allocator.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. Synchronous, active-high.
- rq_alloc_i  in  N  per-requester alloc request.
- rq_free_i  in  N  per-requester free request.
- rq_force_free_i  in  N  per-requester force-free request.
- rq_set_usecnt_i  in  N  per-requester set-use-count request.
- rq_usecnt_i  in  N*U  per-requester use count. Slice k = bits [k*U+U-1:k*U].
- rq_pgaddr_i  in  N*A  per-requester page address for free, force-free and set-usecnt.
- rq_done_o  out  N  one-cycle completion pulse to the served requester.
- rq_pgaddr_o  out  A  allocated page. Valid with the rq_done_o pulse of an ALLOC.
- rq_nomem_o  out  1  registered copy of alloc_nomem_i.
- alloc_o, free_o, force_free_o, set_usecnt_o  out  1 each  allocator command strobes.
- usecnt_o  out  U  use count to the allocator.
- pgaddr_o  out  A  page address to the allocator.
- alloc_done_i  in  1  allocator operation complete.
- alloc_pgaddr_i  in  A  page returned by the allocator. Valid with alloc_done_i.
- alloc_nomem_i  in  1  allocator has no free page.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0. Reset asserted mid-operation abandons the operation. No done pulse is issued. The allocator shares rst_i.
- Requester contract: a requester raises a request and holds it, with its data stable, until its rq_done_o pulse. It drops the request in the cycle after the pulse.
- Multiple request types from one requester: the served type is picked by fixed priority FORCE_FREE > FREE > SET_USECOUNT > ALLOC.
- Eligibility: requester k is eligible if any request bit k is set. While rq_nomem_o=1, a requester whose only request is ALLOC is not eligible. Its request stays pending.
- IDLE state:
  - Search eligible requesters starting at the pointer, ascending, wrapping modulo N. The first hit is granted.
  - On a grant, register the grant index, command type, usecnt_o and pgaddr_o, and assert exactly one command strobe in the next cycle. Go to BUSY.
  - With no eligible requester, stay in IDLE with all strobes low.
- BUSY state:
  - Command strobe and data are held constant.
  - When alloc_done_i=1 is sampled: strobes drop to 0 the next cycle, rq_done_o[grant] pulses 1 for that cycle, and rq_pgaddr_o is loaded with alloc_pgaddr_i on ALLOC (held otherwise). Go to RELEASE.
  - The pointer becomes grant+1 mod N.
- RELEASE state: lasts one cycle. The served requester's request is masked so it cannot be re-granted before it drops. Then return to IDLE.
- Minimum spacing: consecutive grants are separated by allocator latency + 2 cycles. The request-to-strobe latency is 1 cycle.
- Deassertion in BUSY: a request deasserted during BUSY is a protocol violation. The operation still completes and pulses done.
- Widths: usecnt and pgaddr pass through unmodified. There is no arithmetic beyond the pointer increment, which wraps at N-1 to 0.
- rq_nomem_o is alloc_nomem_i registered. A change in nomem during BUSY does not affect the operation in flight.

Test Plan:
- Single requester: requester 2 ALLOC with usecnt=3, allocator returns page 17 after 4 cycles. Expect alloc_o high for 4 cycles, usecnt_o=3, rq_done_o=0b0100 for one cycle, rq_pgaddr_o=17.
- Fairness: all 4 requesters hold FREE continuously with pages 1,2,3,4. Expect grant order 0,1,2,3,0. Each pgaddr_o matches its requester. No requester is served twice before the others are served.
- Mixed request from one requester: requester 1 asserts FREE (page 9) and ALLOC simultaneously. Expect free_o with pgaddr_o=9 first, then alloc_o.
- No memory: alloc_nomem_i=1, requester 0 ALLOC pending, requester 3 FORCE_FREE page 5. Expect force_free_o with pgaddr_o=5 and no alloc_o. After nomem drops, alloc_o is granted to requester 0.
- Set use count: requester 1 SET_USECOUNT with page 40, usecnt=2. Expect set_usecnt_o, pgaddr_o=40, usecnt_o=2, then a done pulse on bit 1. rq_pgaddr_o is unchanged.
- Reset mid-BUSY: assert rst_i while alloc_o=1. Next cycle all strobes and rq_done_o are 0, the state is IDLE and the pointer is 0. After reset, the first grant goes to the lowest eligible index.

Source files
------------

// File: rtl/swc_alloc_arbiter.sv
// swc_alloc_arbiter
// Shares the single command port of the swcore page allocator among
// g_num_ports requesters. Requesters are granted round-robin. The granted
// command and its data are registered and held on the allocator port until
// alloc_done_i is seen. The served requester then gets a one-cycle done pulse,
// plus the allocated page for ALLOC.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   rq_alloc_i             per-requester ALLOC request
//   rq_free_i              per-requester FREE request
//   rq_force_free_i        per-requester FORCE_FREE request
//   rq_set_usecnt_i        per-requester SET_USECOUNT request
//   rq_usecnt_i            per-requester use count, slice k = [k*U +: U]
//   rq_pgaddr_i            per-requester page address, slice k = [k*A +: A]
//   rq_done_o              one-cycle completion pulse to the served requester
//   rq_pgaddr_o            page returned by the last ALLOC
//   rq_nomem_o             registered copy of alloc_nomem_i
//   alloc_o, free_o,
//   force_free_o,
//   set_usecnt_o           allocator command strobes (at most one high)
//   usecnt_o, pgaddr_o     command data to the allocator
//   alloc_done_i           allocator operation complete
//   alloc_pgaddr_i         page from the allocator, valid with alloc_done_i
//   alloc_nomem_i          allocator has no free page
module swc_alloc_arbiter #(
    parameter int g_num_ports       = 4,
    parameter int g_page_addr_width = 10,
    parameter int g_usecnt_width    = 5
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [g_num_ports-1:0]                    rq_alloc_i,
    input  logic [g_num_ports-1:0]                    rq_free_i,
    input  logic [g_num_ports-1:0]                    rq_force_free_i,
    input  logic [g_num_ports-1:0]                    rq_set_usecnt_i,
    input  logic [g_num_ports*g_usecnt_width-1:0]     rq_usecnt_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]  rq_pgaddr_i,
    output logic [g_num_ports-1:0]                    rq_done_o,
    output logic [g_page_addr_width-1:0]              rq_pgaddr_o,
    output logic                                      rq_nomem_o,
    output logic                                      alloc_o,
    output logic                                      free_o,
    output logic                                      force_free_o,
    output logic                                      set_usecnt_o,
    output logic [g_usecnt_width-1:0]                 usecnt_o,
    output logic [g_page_addr_width-1:0]              pgaddr_o,
    input  logic                                      alloc_done_i,
    input  logic [g_page_addr_width-1:0]              alloc_pgaddr_i,
    input  logic                                      alloc_nomem_i
);

    localparam int c_ptr_w = $clog2(g_num_ports);

    // Command vector bit positions: {force_free, free, set_usecnt, alloc}
    localparam int c_cmd_alloc = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [c_ptr_w-1:0]            ptr_q, ptr_d;
    logic [c_ptr_w-1:0]            gnt_q, gnt_d;
    logic [3:0]                    cmd_q, cmd_d;
    logic [g_usecnt_width-1:0]     usecnt_q, usecnt_d;
    logic [g_page_addr_width-1:0]  pgaddr_q, pgaddr_d;
    logic [g_page_addr_width-1:0]  rq_pgaddr_q, rq_pgaddr_d;
    logic [g_num_ports-1:0]        done_q, done_d;
    logic                          nomem_q;

    logic [g_num_ports-1:0]        eligible_s;
    logic                          found_s;
    logic [c_ptr_w-1:0]            sel_s;

    // Fixed type priority within one requester: FORCE_FREE > FREE > SET_USECOUNT > ALLOC
    function automatic logic [3:0] pick_cmd(input logic ff, input logic fr, input logic su);
        logic [3:0] c;
        if (ff) begin
            c = 4'b1000;
        end else if (fr) begin
            c = 4'b0100;
        end else if (su) begin
            c = 4'b0010;
        end else begin
            c = 4'b0001;
        end
        return c;
    endfunction

    // ALLOC-only requesters wait while the allocator is out of memory.
    assign eligible_s = rq_force_free_i | rq_free_i | rq_set_usecnt_i |
                        (rq_alloc_i & {g_num_ports{~nomem_q}});

    // Round-robin search: first eligible requester at or after the pointer
    always_comb begin
        int                 idx_v;
        logic [c_ptr_w-1:0] cand_v;
        idx_v   = 0;
        cand_v  = '0;
        found_s = 1'b0;
        sel_s   = '0;
        for (int i = 0; i < g_num_ports; i++) begin
            idx_v  = (int'(ptr_q) + i) % g_num_ports;
            cand_v = c_ptr_w'(idx_v);
            if (!found_s && eligible_s[cand_v]) begin
                found_s = 1'b1;
                sel_s   = cand_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; RELEASE never grants, which keeps the just-served
    // requester from being re-granted before it drops its request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (alloc_done_i) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of command, data, done pulse, page and pointer
    always_comb begin
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cmd_d       = cmd_q;
        usecnt_d    = usecnt_q;
        pgaddr_d    = pgaddr_q;
        rq_pgaddr_d = rq_pgaddr_q;
        done_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_d    = sel_s;
                    cmd_d    = pick_cmd(rq_force_free_i[sel_s], rq_free_i[sel_s],
                                        rq_set_usecnt_i[sel_s]);
                    usecnt_d = rq_usecnt_i[int'(sel_s)*g_usecnt_width +: g_usecnt_width];
                    pgaddr_d = rq_pgaddr_i[int'(sel_s)*g_page_addr_width +: g_page_addr_width];
                end else begin
                    cmd_d = 4'b0000;
                end
            end
            ST_BUSY: begin
                if (alloc_done_i) begin
                    cmd_d         = 4'b0000;
                    done_d[gnt_q] = 1'b1;
                    if (cmd_q[c_cmd_alloc]) begin
                        rq_pgaddr_d = alloc_pgaddr_i;
                    end else begin
                        rq_pgaddr_d = rq_pgaddr_q;
                    end
                    if (gnt_q == c_ptr_w'(g_num_ports - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_q + c_ptr_w'(1);
                    end
                end else begin
                    cmd_d = cmd_q;
                end
            end
            ST_RELEASE: cmd_d = 4'b0000;
            default:    cmd_d = 4'b0000;
        endcase
    end

    // Datapath registers; reset abandons any operation without a done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            cmd_q       <= 4'b0000;
            usecnt_q    <= '0;
            pgaddr_q    <= '0;
            rq_pgaddr_q <= '0;
            done_q      <= '0;
            nomem_q     <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            usecnt_q    <= usecnt_d;
            pgaddr_q    <= pgaddr_d;
            rq_pgaddr_q <= rq_pgaddr_d;
            done_q      <= done_d;
            nomem_q     <= alloc_nomem_i;
        end
    end

    assign force_free_o = cmd_q[3];
    assign free_o       = cmd_q[2];
    assign set_usecnt_o = cmd_q[1];
    assign alloc_o      = cmd_q[0];
    assign usecnt_o     = usecnt_q;
    assign pgaddr_o     = pgaddr_q;
    assign rq_done_o    = done_q;
    assign rq_pgaddr_o  = rq_pgaddr_q;
    assign rq_nomem_o   = nomem_q;

endmodule

// File: tb/tb_swc_alloc_arbiter.sv
`timescale 1ns/1ps
module tb_swc_alloc_arbiter;

    localparam int N = 4;
    localparam int A = 10;
    localparam int U = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   rq_alloc, rq_free, rq_ff, rq_su;
    logic [N*U-1:0] rq_uc;
    logic [N*A-1:0] rq_pg;
    logic           alloc_done;
    logic [A-1:0]   alloc_pg;
    logic           alloc_nomem;

    logic [N-1:0]   rq_done_o;
    logic [A-1:0]   rq_pgaddr_o;
    logic           rq_nomem_o;
    logic           alloc_o, free_o, force_free_o, set_usecnt_o;
    logic [U-1:0]   usecnt_o;
    logic [A-1:0]   pgaddr_o;

    int total = 0;
    int bad   = 0;

    swc_alloc_arbiter #(
        .g_num_ports(N), .g_page_addr_width(A), .g_usecnt_width(U)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rq_alloc_i(rq_alloc), .rq_free_i(rq_free),
        .rq_force_free_i(rq_ff), .rq_set_usecnt_i(rq_su),
        .rq_usecnt_i(rq_uc), .rq_pgaddr_i(rq_pg),
        .rq_done_o(rq_done_o), .rq_pgaddr_o(rq_pgaddr_o), .rq_nomem_o(rq_nomem_o),
        .alloc_o(alloc_o), .free_o(free_o), .force_free_o(force_free_o),
        .set_usecnt_o(set_usecnt_o), .usecnt_o(usecnt_o), .pgaddr_o(pgaddr_o),
        .alloc_done_i(alloc_done), .alloc_pgaddr_i(alloc_pg), .alloc_nomem_i(alloc_nomem)
    );

    // Strobe encoding used in the bench: {force_free, free, set_usecnt, alloc}
    localparam logic [3:0] S_FF = 4'b1000;
    localparam logic [3:0] S_FR = 4'b0100;
    localparam logic [3:0] S_SU = 4'b0010;
    localparam logic [3:0] S_AL = 4'b0001;

    typedef struct {
        bit           timeout;
        int           wait_cyc;
        logic [3:0]   strb;
        logic [A-1:0] pg;
        logic [U-1:0] uc;
        bit           held_ok;
        int           strobe_cyc;
        logic [N-1:0] done_vec;
        logic [A-1:0] rq_pg;
        logic [3:0]   strb_after;
        logic [N-1:0] done_after;
    } txn_t;

    function automatic logic [3:0] strobes();
        return {force_free_o, free_o, set_usecnt_o, alloc_o};
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; rq_alloc = '0; rq_free = '0; rq_ff = '0; rq_su = '0;
        alloc_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Acts as the allocator for one operation and as the served requester:
    // collects observations; the calling test does the comparisons.
    task automatic do_txn(input int lat, input logic [A-1:0] page, input bit nomem_next,
                          output txn_t t);
        t.timeout = 1'b1; t.wait_cyc = 0; t.strb = '0; t.pg = '0; t.uc = '0;
        t.held_ok = 1'b0; t.strobe_cyc = 0; t.done_vec = '0; t.rq_pg = '0;
        t.strb_after = '0; t.done_after = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (strobes() != 4'b0000) begin
                t.timeout = 1'b0; t.wait_cyc = c;
                break;
            end
        end
        if (t.timeout) return;
        t.strb = strobes(); t.pg = pgaddr_o; t.uc = usecnt_o;
        t.held_ok = 1'b1; t.strobe_cyc = 1;
        for (int c = 1; c < lat; c++) begin
            @(posedge clk); #1;
            if (strobes() != 4'b0000) t.strobe_cyc++;
            if (strobes() != t.strb || pgaddr_o != t.pg || usecnt_o != t.uc) t.held_ok = 1'b0;
        end
        alloc_done = 1'b1; alloc_pg = page; alloc_nomem = nomem_next;
        @(posedge clk); #1;
        alloc_done = 1'b0; alloc_pg = '0;
        t.done_vec = rq_done_o; t.rq_pg = rq_pgaddr_o; t.strb_after = strobes();
        @(posedge clk); #1;
        t.done_after = rq_done_o;
        // Served requester drops its served request in the cycle after the pulse
        for (int j = 0; j < N; j++) begin
            if (t.done_vec[j] === 1'b1) begin
                if (rq_ff[j]) rq_ff[j] = 1'b0;
                else if (rq_free[j]) rq_free[j] = 1'b0;
                else if (rq_su[j]) rq_su[j] = 1'b0;
                else rq_alloc[j] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; alloc_nomem = 1'b1; rq_free = '1; alloc_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL reset_strobes: got %b want 0000", strobes()); end
        total++; if (rq_done_o !== '0) begin bad++; $display("FAIL reset_done: got %b want 0", rq_done_o); end
        total++; if (rq_pgaddr_o !== '0) begin bad++; $display("FAIL reset_rq_pgaddr: got %0d want 0", rq_pgaddr_o); end
        total++; if (rq_nomem_o !== 1'b0) begin bad++; $display("FAIL reset_nomem: got %b want 0", rq_nomem_o); end
        total++; if (pgaddr_o !== '0 || usecnt_o !== '0) begin bad++; $display("FAIL reset_data: got pg=%0d uc=%0d want 0 0", pgaddr_o, usecnt_o); end
        rq_free = '0; alloc_nomem = 1'b0; rst = 1'b0;
    endtask

    task automatic test_single();
        txn_t t;
        do_reset();
        rq_alloc[2] = 1'b1; rq_uc[2*U +: U] = 5'd3; rq_pg[2*A +: A] = 10'd100;
        do_txn(4, 10'd17, 1'b0, t);
        total++; if (t.timeout) begin bad++; $display("FAIL single_timeout: got no strobe want strobe"); end
        total++; if (t.wait_cyc != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", t.wait_cyc); end
        total++; if (t.strb !== S_AL) begin bad++; $display("FAIL single_strobe: got %b want %b", t.strb, S_AL); end
        total++; if (t.uc !== 5'd3) begin bad++; $display("FAIL single_usecnt: got %0d want 3", t.uc); end
        total++; if (t.strobe_cyc != 4 || !t.held_ok) begin bad++; $display("FAIL single_hold: got %0d cycles held=%0d want 4 held=1", t.strobe_cyc, t.held_ok); end
        total++; if (t.done_vec !== 4'b0100) begin bad++; $display("FAIL single_done: got %b want 0100", t.done_vec); end
        total++; if (t.rq_pg !== 10'd17) begin bad++; $display("FAIL single_page: got %0d want 17", t.rq_pg); end
        total++; if (t.strb_after !== 4'b0000 || t.done_after !== '0) begin bad++; $display("FAIL single_release: got strb=%b done=%b want 0000 0000", t.strb_after, t.done_after); end
    endtask

    task automatic test_fairness();
        txn_t t;
        int   exp_k;
        do_reset();
        for (int k = 0; k < N; k++) rq_pg[k*A +: A] = A'(k + 1);
        rq_free = '1;
        for (int i = 0; i < 5; i++) begin
            exp_k = i % N;
            do_txn($urandom_range(1, 4), A'($urandom), 1'b0, t);
            rq_free = '1;
            total++; if (t.strb !== S_FR || t.pg !== A'(exp_k + 1)) begin bad++; $display("FAIL fair_cmd%0d: got strb=%b pg=%0d want %b %0d", i, t.strb, t.pg, S_FR, exp_k + 1); end
            total++; if (t.done_vec !== onehot(exp_k)) begin bad++; $display("FAIL fair_order%0d: got %b want %b", i, t.done_vec, onehot(exp_k)); end
            total++; if (t.wait_cyc != 1) begin bad++; $display("FAIL fair_spacing%0d: got %0d want 1", i, t.wait_cyc); end
        end
        rq_free = '0;
        total++; if (rq_pgaddr_o !== '0) begin bad++; $display("FAIL fair_page_held: got %0d want 0", rq_pgaddr_o); end
    endtask

    task automatic test_mixed();
        txn_t t;
        do_reset();
        rq_free[1] = 1'b1; rq_alloc[1] = 1'b1; rq_pg[1*A +: A] = 10'd9; rq_uc[1*U +: U] = 5'd7;
        do_txn(2, 10'd55, 1'b0, t);
        total++; if (t.strb !== S_FR || t.pg !== 10'd9) begin bad++; $display("FAIL mixed_first: got strb=%b pg=%0d want %b 9", t.strb, t.pg, S_FR); end
        total++; if (t.done_vec !== 4'b0010 || t.rq_pg !== '0) begin bad++; $display("FAIL mixed_first_done: got %b page=%0d want 0010 0", t.done_vec, t.rq_pg); end
        do_txn(3, 10'd66, 1'b0, t);
        total++; if (t.strb !== S_AL || t.uc !== 5'd7) begin bad++; $display("FAIL mixed_second: got strb=%b uc=%0d want %b 7", t.strb, t.uc, S_AL); end
        total++; if (t.done_vec !== 4'b0010 || t.rq_pg !== 10'd66) begin bad++; $display("FAIL mixed_second_done: got %b page=%0d want 0010 66", t.done_vec, t.rq_pg); end
    endtask

    task automatic test_nomem();
        txn_t t;
        int   seen;
        do_reset();
        alloc_nomem = 1'b1;
        @(posedge clk); #1;
        total++; if (rq_nomem_o !== 1'b1) begin bad++; $display("FAIL nomem_reg: got %b want 1", rq_nomem_o); end
        rq_alloc[0] = 1'b1; rq_pg[0] = 1'b0;
        rq_ff[3] = 1'b1; rq_pg[3*A +: A] = 10'd5;
        do_txn(3, 10'd200, 1'b1, t);
        total++; if (t.strb !== S_FF || t.pg !== 10'd5) begin bad++; $display("FAIL nomem_ff: got strb=%b pg=%0d want %b 5", t.strb, t.pg, S_FF); end
        total++; if (t.done_vec !== 4'b1000 || t.rq_pg !== '0) begin bad++; $display("FAIL nomem_ff_done: got %b page=%0d want 1000 0", t.done_vec, t.rq_pg); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (strobes() != 4'b0000) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL nomem_blocked: got %0d strobe cycles want 0", seen); end
        alloc_nomem = 1'b0;
        do_txn(2, 10'd300, 1'b0, t);
        total++; if (t.wait_cyc != 2 || t.strb !== S_AL) begin bad++; $display("FAIL nomem_release: got wait=%0d strb=%b want 2 %b", t.wait_cyc, t.strb, S_AL); end
        total++; if (t.done_vec !== 4'b0001 || t.rq_pg !== 10'd300) begin bad++; $display("FAIL nomem_alloc_done: got %b page=%0d want 0001 300", t.done_vec, t.rq_pg); end
    endtask

    task automatic test_setuc();
        txn_t t;
        rq_su[1] = 1'b1; rq_pg[1*A +: A] = 10'd40; rq_uc[1*U +: U] = 5'd2;
        do_txn(2, 10'h3AB, 1'b0, t);
        total++; if (t.strb !== S_SU || t.pg !== 10'd40 || t.uc !== 5'd2) begin bad++; $display("FAIL setuc_cmd: got strb=%b pg=%0d uc=%0d want %b 40 2", t.strb, t.pg, t.uc, S_SU); end
        total++; if (t.done_vec !== 4'b0010 || t.rq_pg !== 10'd300) begin bad++; $display("FAIL setuc_done: got %b page=%0d want 0010 300", t.done_vec, t.rq_pg); end
    endtask

    task automatic test_reset_busy();
        txn_t t;
        bit   got;
        rq_alloc[3] = 1'b1; rq_pg[3*A +: A] = 10'd11;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (alloc_o === 1'b1) begin got = 1'b1; break; end
        end
        total++; if (!got) begin bad++; $display("FAIL rstbusy_grant: got no alloc_o want alloc_o"); end
        rq_free[1] = 1'b1; rq_pg[1*A +: A] = 10'd21;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (strobes() !== 4'b0000 || rq_done_o !== '0) begin bad++; $display("FAIL rstbusy_clear: got strb=%b done=%b want 0000 0000", strobes(), rq_done_o); end
        total++; if (rq_pgaddr_o !== '0) begin bad++; $display("FAIL rstbusy_page: got %0d want 0", rq_pgaddr_o); end
        do_txn(2, 10'd77, 1'b0, t);
        total++; if (t.wait_cyc != 1 || t.strb !== S_FR || t.pg !== 10'd21) begin bad++; $display("FAIL rstbusy_first: got wait=%0d strb=%b pg=%0d want 1 %b 21", t.wait_cyc, t.strb, t.pg, S_FR); end
        total++; if (t.done_vec !== 4'b0010) begin bad++; $display("FAIL rstbusy_first_done: got %b want 0010", t.done_vec); end
        do_txn(2, 10'd88, 1'b0, t);
        total++; if (t.strb !== S_AL || t.done_vec !== 4'b1000 || t.rq_pg !== 10'd88) begin bad++; $display("FAIL rstbusy_second: got strb=%b done=%b page=%0d want %b 1000 88", t.strb, t.done_vec, t.rq_pg, S_AL); end
    endtask

    // Random traffic against a transaction-level model: pending request table,
    // round-robin pointer, nomem flag and last allocated page.
    task automatic test_random();
        txn_t         t;
        int           m_ptr, k, c, seen, lat;
        bit           m_nm, nn;
        logic [A-1:0] m_rqpg, page, e_pg;
        logic [U-1:0] e_uc;
        logic [3:0]   ty, e_strb;
        alloc_nomem = 1'b0;
        do_reset();
        m_ptr = 0; m_nm = 1'b0; m_rqpg = '0;
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < N; j++) begin
                if (!(rq_alloc[j] | rq_free[j] | rq_ff[j] | rq_su[j]) && $urandom_range(0, 1) == 1) begin
                    ty = 4'($urandom_range(1, 15));
                    rq_pg[j*A +: A] = A'($urandom);
                    rq_uc[j*U +: U] = U'($urandom);
                    {rq_ff[j], rq_free[j], rq_su[j], rq_alloc[j]} = ty;
                end
            end
            if ((rq_alloc | rq_free | rq_ff | rq_su) == '0) begin
                k = $urandom_range(0, N - 1);
                rq_pg[k*A +: A] = A'($urandom);
                rq_free[k] = 1'b1;
            end
            k = -1;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (k < 0 && (rq_ff[c] || rq_free[c] || rq_su[c] || (rq_alloc[c] && !m_nm))) k = c;
            end
            if (k < 0) begin
                seen = 0;
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    if (strobes() != 4'b0000) seen++;
                end
                total++; if (seen != 0) begin bad++; $display("FAIL rand_blocked it=%0d: got %0d strobe cycles want 0", it, seen); end
                alloc_nomem = 1'b0; m_nm = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (k < 0 && (rq_ff[c] || rq_free[c] || rq_su[c] || rq_alloc[c])) k = c;
                end
            end
            e_strb = rq_ff[k] ? S_FF : rq_free[k] ? S_FR : rq_su[k] ? S_SU : S_AL;
            e_pg = rq_pg[k*A +: A];
            e_uc = rq_uc[k*U +: U];
            lat  = $urandom_range(1, 5);
            page = A'($urandom);
            nn   = ($urandom_range(0, 3) == 0);
            do_txn(lat, page, nn, t);
            if (e_strb == S_AL) m_rqpg = page;
            m_ptr = (k + 1) % N;
            m_nm  = nn;
            total++; if (t.strb !== e_strb || t.done_vec !== onehot(k)) begin bad++; $display("FAIL rand_grant it=%0d: got strb=%b done=%b want %b %b", it, t.strb, t.done_vec, e_strb, onehot(k)); end
            total++; if (t.pg !== e_pg || t.uc !== e_uc) begin bad++; $display("FAIL rand_data it=%0d: got pg=%0d uc=%0d want %0d %0d", it, t.pg, t.uc, e_pg, e_uc); end
            total++; if (t.strobe_cyc != lat || !t.held_ok) begin bad++; $display("FAIL rand_hold it=%0d: got %0d cycles held=%0d want %0d held=1", it, t.strobe_cyc, t.held_ok, lat); end
            total++; if (t.rq_pg !== m_rqpg) begin bad++; $display("FAIL rand_page it=%0d: got %0d want %0d", it, t.rq_pg, m_rqpg); end
        end
        rq_alloc = '0; rq_free = '0; rq_ff = '0; rq_su = '0; alloc_nomem = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rq_alloc = '0; rq_free = '0; rq_ff = '0; rq_su = '0;
        rq_uc = '0; rq_pg = '0; alloc_done = 1'b0; alloc_pg = '0; alloc_nomem = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_mixed();
        test_nomem();
        test_setuc();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
